// File: rtl/wk_extract_pkg.sv
// Shared types and helpers for the QRD-RLS weight extraction cell:
// FSM state encoding, signed range limits and the update-counter width.
package wk_extract_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } wk_state_e;

    function automatic longint max_signed(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint min_signed(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Wide enough to hold n itself, so the counter can sit at n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wk_mac_sat.sv
// Combinational w - ((a*b) >>> FRAC_BITS) with the result reduced to DATA_LENGTH bits.
// Saturation and the sat_o port exist only when WK_EXTRACT_SAT_EN is defined.
module wk_mac_sat
    import wk_extract_pkg::*;
#(
    parameter int DATA_LENGTH = 16,
    parameter int FRAC_BITS   = 8
) (
    input  logic signed [DATA_LENGTH-1:0] a_i,
    input  logic signed [DATA_LENGTH-1:0] b_i,
    input  logic signed [DATA_LENGTH-1:0] w_i,
    output logic signed [DATA_LENGTH-1:0] diff_o
`ifdef WK_EXTRACT_SAT_EN
    ,
    output logic                          sat_o
`endif
);

    localparam int PW = 2 * DATA_LENGTH;
    localparam int DW = 2 * DATA_LENGTH + 1;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_s;
    logic signed [DW-1:0] diff_full;

    assign prod      = a_i * b_i;
    assign prod_s    = prod >>> FRAC_BITS;
    assign diff_full = $signed({{(DW-DATA_LENGTH){w_i[DATA_LENGTH-1]}}, w_i})
                     - $signed({prod_s[PW-1], prod_s});

`ifdef WK_EXTRACT_SAT_EN
    localparam logic signed [DW-1:0] MAX_W = DW'(max_signed(DATA_LENGTH));
    localparam logic signed [DW-1:0] MIN_W = DW'(min_signed(DATA_LENGTH));

    function automatic logic signed [DATA_LENGTH-1:0] saturate(input logic signed [DW-1:0] x);
        if (x > MAX_W)
            return MAX_W[DATA_LENGTH-1:0];
        else if (x < MIN_W)
            return MIN_W[DATA_LENGTH-1:0];
        else
            return x[DATA_LENGTH-1:0];
    endfunction

    function automatic logic clipped(input logic signed [DW-1:0] x);
        return (x > MAX_W) || (x < MIN_W);
    endfunction

    assign diff_o = saturate(diff_full);
    assign sat_o  = clipped(diff_full);
`else
    function automatic logic signed [DATA_LENGTH-1:0] wrap(input logic signed [DW-1:0] x);
        return x[DATA_LENGTH-1:0];
    endfunction

    assign diff_o = wrap(diff_full);
`endif

endmodule

// File: rtl/wk_extract_cell_p.sv
// QRD-RLS back-substitution weight cell: accumulates w <= w - a*b over NUM_UPDATES beats,
// forwards a downstream. Optional saturation plus sticky sat_flag via WK_EXTRACT_SAT_EN.
module wk_extract_cell_p
    import wk_extract_pkg::*;
#(
    parameter int DATA_LENGTH = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_UPDATES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [DATA_LENGTH-1:0] ai_in,
    input  logic [DATA_LENGTH-1:0] bi_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_LENGTH-1:0] ak_out,
    output logic                   ak_valid,
    output logic [DATA_LENGTH-1:0] wk_out,
    output logic                   wk_valid,
    output logic                   busy
`ifdef WK_EXTRACT_SAT_EN
    ,
    output logic                   sat_flag
`endif
);

    localparam int CW = cnt_width(NUM_UPDATES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_UPDATES);

    wk_state_e                     state_q;
    logic [CW-1:0]                 cnt_q;
    logic [CW-1:0]                 cnt_d;
    logic signed [DATA_LENGTH-1:0] w_q;
    logic signed [DATA_LENGTH-1:0] w_d;
    logic [DATA_LENGTH-1:0]        ak_q;
    logic                          akv_q;
    logic                          accept;

    assign in_ready = (state_q != HOLD) && !clear;
    assign accept   = in_valid && in_ready;
    assign cnt_d    = cnt_q + CW'(1);

`ifdef WK_EXTRACT_SAT_EN
    logic sat_d;
    logic sat_q;

    wk_mac_sat #(
        .DATA_LENGTH(DATA_LENGTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .a_i   ($signed(ai_in)),
        .b_i   ($signed(bi_in)),
        .w_i   (w_q),
        .diff_o(w_d),
        .sat_o (sat_d)
    );

    // Sticky clip indicator; only an accepted beat can raise it.
    always_ff @(posedge clk) begin
        if (rst || clear)
            sat_q <= 1'b0;
        else if (accept && sat_d)
            sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    wk_mac_sat #(
        .DATA_LENGTH(DATA_LENGTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .a_i   ($signed(ai_in)),
        .b_i   ($signed(bi_in)),
        .w_i   (w_q),
        .diff_o(w_d)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            ak_q    <= '0;
            akv_q   <= 1'b0;
        end else if (clear) begin
            // The forwarded operand survives a clear; only its strobe drops.
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            akv_q   <= 1'b0;
        end else begin
            akv_q <= accept;
            if (accept) begin
                w_q   <= w_d;
                ak_q  <= ai_in;
                cnt_q <= cnt_d;
                if (cnt_d == LAST_CNT)
                    state_q <= HOLD;
                else
                    state_q <= RUN;
            end
        end
    end

    assign ak_out   = ak_q;
    assign ak_valid = akv_q;
    assign wk_out   = w_q;
    assign wk_valid = (state_q == HOLD);
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_wk_extract_cell_p.sv
// Directed bench for wk_extract_cell_p with a reference model and a scoreboard of
// accepted beats; sat_flag is checked when WK_EXTRACT_SAT_EN is defined.
module tb_wk_extract_cell_p;

    localparam int DL = 16;
    localparam int FB = 8;
    localparam int NU = 4;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [DL-1:0] ai_in;
    logic [DL-1:0] bi_in;
    logic          in_valid;
    logic          in_ready;
    logic [DL-1:0] ak_out;
    logic          ak_valid;
    logic [DL-1:0] wk_out;
    logic          wk_valid;
    logic          busy;
`ifdef WK_EXTRACT_SAT_EN
    logic          sat_flag;
`endif

    wk_extract_cell_p #(
        .DATA_LENGTH(DL),
        .FRAC_BITS  (FB),
        .NUM_UPDATES(NU)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .ai_in   (ai_in),
        .bi_in   (bi_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ak_out  (ak_out),
        .ak_valid(ak_valid),
        .wk_out  (wk_out),
        .wk_valid(wk_valid),
        .busy    (busy)
`ifdef WK_EXTRACT_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DL-1:0] wk;
        logic [DL-1:0] ak;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;

    logic signed [DL-1:0] w_m;
    logic [DL-1:0]        ak_m;
    int                   cnt_m;
    logic                 run_m;
    logic                 hold_m;
    logic                 sat_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset(input logic full);
        w_m    = '0;
        cnt_m  = 0;
        run_m  = 1'b0;
        hold_m = 1'b0;
        sat_m  = 1'b0;
        if (full) ak_m = '0;
    endtask

    // One clock: drive inputs, update the model, advance, then check every output.
    task automatic step(input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input logic v, input logic c, input logic r);
        logic                   acc;
        logic signed [DL-1:0]   as;
        logic signed [DL-1:0]   bs;
        logic signed [2*DL-1:0] p;
        logic signed [2*DL:0]   d;
        exp_t                   e;
        ai_in = a; bi_in = b; in_valid = v; clear = c; rst = r;
        #1;
        if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, !hold_m && !c});
        acc = v && !c && !r && !hold_m;
        if (r) begin
            model_reset(1'b1);
        end else if (c) begin
            model_reset(1'b0);
        end else if (acc) begin
            as = $signed(a);
            bs = $signed(b);
            p  = as * bs;
            p  = p >>> FB;
            d  = w_m - p;
`ifdef WK_EXTRACT_SAT_EN
            if (d > 33'sd32767) begin
                w_m = 16'sh7FFF; sat_m = 1'b1;
            end else if (d < -33'sd32768) begin
                w_m = 16'sh8000; sat_m = 1'b1;
            end else begin
                w_m = d[DL-1:0];
            end
`else
            w_m = d[DL-1:0];
`endif
            ak_m  = a;
            cnt_m = cnt_m + 1;
            hold_m = (cnt_m == NU);
            run_m  = !hold_m;
            sb.push_back('{wk: w_m, ak: a});
        end
        @(posedge clk);
        #1;
        chk("ak_valid", {31'd0, ak_valid}, {31'd0, acc});
        if (ak_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_wk_out", {16'd0, wk_out}, {16'd0, e.wk});
            chk("sb_ak_out", {16'd0, ak_out}, {16'd0, e.ak});
        end
        chk("wk_out", {16'd0, wk_out}, {16'd0, w_m});
        chk("ak_out", {16'd0, ak_out}, {16'd0, ak_m});
        chk("wk_valid", {31'd0, wk_valid}, {31'd0, hold_m});
        chk("busy", {31'd0, busy}, {31'd0, run_m});
`ifdef WK_EXTRACT_SAT_EN
        chk("sat_flag", {31'd0, sat_flag}, {31'd0, sat_m});
`endif
    endtask

    initial begin
        model_reset(1'b1);
        ai_in = '0; bi_in = '0; in_valid = 1'b0; clear = 1'b0; rst = 1'b1;

        // Reset state
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Single beat 1.0 * 2.0 -> 0xFE00, busy
        step(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);
        chk("first_wk", {16'd0, wk_out}, 32'h0000_FE00);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Four back-to-back beats, then HOLD ignores a fifth
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NU; i++)
            step(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0);
        chk("hold_wk", {16'd0, wk_out}, 32'h0000_FC00);
        step(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Negative operand with truncation toward minus infinity
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'hFF80, 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("trunc_wk", {16'd0, wk_out}, 32'h0000_0001);

        // Overflow: wrap or saturate
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
`ifdef WK_EXTRACT_SAT_EN
        chk("ovf_wk", {16'd0, wk_out}, 32'h0000_8000);
`else
        chk("ovf_wk", {16'd0, wk_out}, 32'h0000_0100);
`endif
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        // clear with in_valid during RUN: beat dropped, restart at count 1
        step(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0300, 16'h0100, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NU; i++)
            step(16'h0080, 16'h0200, 1'b1, 1'b0, 1'b0);
        chk("restart_wk", {16'd0, wk_out}, 32'h0000_FC00);

        // rst mid-RUN discards the partial weight and needs NU fresh beats
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0200, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0200, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0200, 16'h0100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NU; i++)
            step(16'hFF00, 16'h0100, 1'b1, 1'b0, 1'b0);
        chk("post_rst_wk", {16'd0, wk_out}, 32'h0000_0400);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
